// File: rtl/uart_rx_core.sv
// uart_rx_core: UART receive framer fed by an external 9x sample-pulse generator.
// Synchronises rx, finds the start edge, majority-votes each bit and shifts data in
// LSB first. Define UART_RX_PARITY_EN to insert a parity bit between data and stop.
module uart_rx_core #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    input  logic                  sample_clk,
    output logic                  rx_start,
    output logic                  rx_done,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  frame_err,
    output logic                  parity_err
);

    localparam int unsigned     IdxW    = $clog2(DATA_WIDTH);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(DATA_WIDTH - 1);

    // StDone is the rx_done cycle; StRearm keeps the cycle after it blind to start edges.
    typedef enum logic [2:0] {
        StIdle, StStart, StData, StParity, StStop, StDone, StRearm
    } state_e;

    state_e                state_q, state_d;
    logic                  rx_meta_q, rx_s_q, rx_prev_q;
    logic [3:0]            smp_cnt_q, smp_cnt_d;
    logic                  s3_q, s3_d, s4_q, s4_d;
    logic                  bit_v_q, bit_v_d;
    logic [IdxW-1:0]       bit_idx_q, bit_idx_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  busy_q, busy_d;
    logic                  rx_start_q, rx_start_d;
    logic                  rx_done_q, rx_done_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  frame_err_q, frame_err_d;
    logic                  parity_err_q, parity_err_d;

    logic fall, in_frame, vote, bit_end, stop_close, par_ok;

    assign fall       = rx_prev_q & ~rx_s_q;
    assign in_frame   = (state_q == StStart) || (state_q == StData) ||
                        (state_q == StParity) || (state_q == StStop);
    // 2-of-3 vote; the third sample is the live one taken at smp_cnt 5.
    assign vote       = (s3_q & s4_q) | (s3_q & rx_s_q) | (s4_q & rx_s_q);
    assign bit_end    = in_frame && sample_clk && (smp_cnt_q == 4'd8);
    assign stop_close = (state_q == StStop) && sample_clk && (smp_cnt_q == 4'd5);

`ifdef UART_RX_PARITY_EN
    logic par_q, par_d;
    assign par_ok     = ((^shift_q) ^ par_q) == PARITY_ODD;
    assign parity_err = parity_err_q;
`else
    logic unused_par_cfg;
    assign unused_par_cfg = PARITY_ODD ^ parity_err_q;
    assign par_ok         = 1'b1;
    assign parity_err     = 1'b0;
`endif

    assign rx_start  = rx_start_q;
    assign rx_done   = rx_done_q;
    assign busy      = busy_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;

    // State, datapath and synchroniser registers; sync FFs preset to idle-high.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            rx_prev_q    <= 1'b1;
            state_q      <= StIdle;
            smp_cnt_q    <= '0;
            s3_q         <= 1'b0;
            s4_q         <= 1'b0;
            bit_v_q      <= 1'b0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            rx_data_q    <= '0;
            busy_q       <= 1'b0;
            rx_start_q   <= 1'b0;
            rx_done_q    <= 1'b0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q        <= 1'b0;
`endif
        end else begin
            rx_meta_q    <= rx;
            rx_s_q       <= rx_meta_q;
            rx_prev_q    <= rx_s_q;
            state_q      <= state_d;
            smp_cnt_q    <= smp_cnt_d;
            s3_q         <= s3_d;
            s4_q         <= s4_d;
            bit_v_q      <= bit_v_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            rx_data_q    <= rx_data_d;
            busy_q       <= busy_d;
            rx_start_q   <= rx_start_d;
            rx_done_q    <= rx_done_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
`ifdef UART_RX_PARITY_EN
            par_q        <= par_d;
`endif
        end
    end

    // Next-state: sample counting/voting plus frame sequencing.
    always_comb begin
        state_d      = state_q;
        smp_cnt_d    = smp_cnt_q;
        s3_d         = s3_q;
        s4_d         = s4_q;
        bit_v_d      = bit_v_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        rx_data_d    = rx_data_q;
        busy_d       = busy_q;
        rx_start_d   = 1'b0;
        rx_done_d    = 1'b0;
        rx_valid_d   = 1'b0;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d        = par_q;
`endif

        if (in_frame && sample_clk) begin
            smp_cnt_d = (smp_cnt_q == 4'd8) ? 4'd0 : smp_cnt_q + 4'd1;
            if (smp_cnt_q == 4'd3) s3_d = rx_s_q;
            if (smp_cnt_q == 4'd4) s4_d = rx_s_q;
            if (smp_cnt_q == 4'd5) bit_v_d = vote;
        end

        case (state_q)
            StIdle: begin
                if (fall) begin
                    rx_start_d = 1'b1;
                    busy_d     = 1'b1;
                    smp_cnt_d  = '0;
                    state_d    = StStart;
                end
            end
            StStart: begin
                if (bit_end) begin
                    if (bit_v_q) begin
                        rx_done_d = 1'b1;
                        state_d   = StDone;
                    end else begin
                        bit_idx_d = '0;
                        state_d   = StData;
                    end
                end
            end
            StData: begin
                if (bit_end) begin
                    shift_d = {bit_v_q, shift_q[DATA_WIDTH-1:1]};
                    if (bit_idx_q == LastIdx) begin
`ifdef UART_RX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + IdxW'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (bit_end) begin
                    par_d   = bit_v_q;
                    state_d = StStop;
                end
            end
`endif
            StStop: begin
                // Close mid-stop-bit so the next start edge is never missed.
                if (stop_close) begin
                    rx_done_d = 1'b1;
                    state_d   = StDone;
                    if (!vote) begin
                        frame_err_d = 1'b1;
                    end else if (!par_ok) begin
                        parity_err_d = 1'b1;
                    end else begin
                        rx_valid_d = 1'b1;
                        rx_data_d  = shift_q;
                    end
                end
            end
            StDone: begin
                busy_d  = 1'b0;
                state_d = StRearm;
            end
            StRearm: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: drives serial frames at 432 clk per bit, emulates the 9x
// sample-pulse generator (one pulse every 48 clk between rx_start and rx_done)
// and checks outcomes against a frame-level model of what each frame must yield.
`timescale 1ns/1ps
module tb_uart_rx_core;

    localparam int unsigned DW      = 8;
    localparam bit          POD     = 1'b0;
    localparam int          BIT_CLK = 432;
    localparam int          SMP_CLK = 48;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx;
    logic          sample_clk;
    logic          rx_start, rx_done, busy, rx_valid, frame_err, parity_err;
    logic [DW-1:0] rx_data;

    int n_total = 0;
    int n_bad   = 0;

    // Monitor tallies, cleared per test.
    int            n_start, n_done, n_valid, n_ferr, n_perr, n_pulse, n_viol;
    logic [DW-1:0] got_q[$];
    logic [DW-1:0] last_good;

    uart_rx_core #(
        .DATA_WIDTH(DW),
        .PARITY_ODD(POD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .sample_clk(sample_clk),
        .rx_start  (rx_start),
        .rx_done   (rx_done),
        .busy      (busy),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .parity_err(parity_err)
    );

    always #10 clk = ~clk;

    // Monitor first, then sample-pulse generator, both 1 ns after each edge.
    initial begin
        bit            gen_on;
        int            gen_cnt;
        logic          prev_done;
        logic [DW-1:0] prev_data;
        gen_on     = 1'b0;
        gen_cnt    = 0;
        prev_done  = 1'b0;
        prev_data  = '0;
        sample_clk = 1'b0;
        n_viol     = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rx_start)   n_start++;
            if (rx_done)    n_done++;
            if (frame_err)  n_ferr++;
            if (parity_err) n_perr++;
            if (sample_clk) n_pulse++;
            if (rx_valid) begin
                n_valid++;
                got_q.push_back(rx_data);
            end
            if ((rx_valid || frame_err || parity_err) && !rx_done) n_viol++;
            if (32'(rx_valid) + 32'(frame_err) + 32'(parity_err) > 1) n_viol++;
            if (rx_start && !busy) n_viol++;
            if (prev_done && busy) n_viol++;
            if (!rst && !rx_valid && rx_data !== prev_data) n_viol++;
            prev_done = rx_done;
            prev_data = rx_data;

            if (rst || rx_done) begin
                gen_on     = 1'b0;
                sample_clk = 1'b0;
            end else if (rx_start) begin
                gen_on     = 1'b1;
                gen_cnt    = 0;
                sample_clk = 1'b0;
            end else if (gen_on) begin
                gen_cnt++;
                if (gen_cnt == SMP_CLK) begin
                    sample_clk = 1'b1;
                    gen_cnt    = 0;
                end else begin
                    sample_clk = 1'b0;
                end
            end else begin
                sample_clk = 1'b0;
            end
        end
    end

    initial begin
        #(20ns * 95000);
        $display("FAIL watchdog: simulation still running at cycle limit, want finished");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic clear_mon();
        n_start = 0;
        n_done  = 0;
        n_valid = 0;
        n_ferr  = 0;
        n_perr  = 0;
        n_pulse = 0;
        got_q.delete();
    endtask

    task automatic wait_idle(output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            if (!busy) begin
                timed_out = 1'b0;
                break;
            end
            tick(1);
        end
        tick(8);
    endtask

    // Start bit, LSB-first data, optional parity, stop. glitch_bit inverts rx briefly
    // around the middle sample of that bit position.
    task automatic send_frame(input logic [DW-1:0] d, input logic stop_v,
                              input int glitch_bit, input logic par_flip);
        bit bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < int'(DW); i++) bits.push_back(d[i]);
`ifdef UART_RX_PARITY_EN
        bits.push_back((^d) ^ POD ^ par_flip);
`else
        if (par_flip) bits.push_back(1'b1);
`endif
        bits.push_back(stop_v);
        for (int k = 0; k < bits.size(); k++) begin
            rx = bits[k];
            if (k == glitch_bit) begin
                tick(230);
                rx = ~bits[k];
                tick(25);
                rx = bits[k];
                tick(BIT_CLK - 255);
            end else begin
                tick(BIT_CLK);
            end
        end
        rx = 1'b1;
    endtask

    task automatic test_reset();
        clear_mon();
        rst = 1'b1;
        rx  = 1'b1;
        tick(3);
        n_total++;
        if ({rx_start, rx_done, busy, rx_valid, frame_err, parity_err} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got %b want 000000",
                     {rx_start, rx_done, busy, rx_valid, frame_err, parity_err});
        end
        n_total++;
        if (rx_data !== '0) begin
            n_bad++;
            $display("FAIL reset_data: got %h want 00", rx_data);
        end
        rst = 1'b0;
        tick(20);
        n_total++;
        if (n_start !== 0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle: starts %0d busy %b want 0 0", n_start, busy);
        end
        last_good = '0;
    endtask

    task automatic test_good_frame();
        bit to;
        clear_mon();
        send_frame(8'hA5, 1'b1, -1, 1'b0);
        wait_idle(to);
        last_good = 8'hA5;
        n_total++;
        if (to) begin n_bad++; $display("FAIL good_idle: busy stuck, want 0"); end
        n_total++;
        if (n_start !== 1 || n_done !== 1) begin
            n_bad++;
            $display("FAIL good_handshake: start %0d done %0d want 1 1", n_start, n_done);
        end
        n_total++;
        if (n_valid !== 1 || n_ferr !== 0) begin
            n_bad++;
            $display("FAIL good_status: valid %0d ferr %0d want 1 0", n_valid, n_ferr);
        end
        n_total++;
        if (rx_data !== 8'hA5) begin
            n_bad++;
            $display("FAIL good_data: got %h want a5", rx_data);
        end
    endtask

    task automatic test_false_start();
        bit to;
        clear_mon();
        rx = 1'b0;
        tick(100);
        rx = 1'b1;
        wait_idle(to);
        n_total++;
        if (to || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL false_idle: busy %b want 0", busy);
        end
        n_total++;
        if (n_start !== 1 || n_done !== 1) begin
            n_bad++;
            $display("FAIL false_handshake: start %0d done %0d want 1 1", n_start, n_done);
        end
        n_total++;
        if (n_pulse !== 9) begin
            n_bad++;
            $display("FAIL false_pulses: got %0d pulses want 9", n_pulse);
        end
        n_total++;
        if (n_valid !== 0 || n_ferr !== 0 || n_perr !== 0) begin
            n_bad++;
            $display("FAIL false_status: valid %0d ferr %0d perr %0d want 0 0 0",
                     n_valid, n_ferr, n_perr);
        end
    endtask

    task automatic test_frame_err();
        bit to;
        clear_mon();
        send_frame(8'h3C, 1'b0, -1, 1'b0);
        wait_idle(to);
        n_total++;
        if (n_ferr !== 1 || n_valid !== 0 || n_done !== 1) begin
            n_bad++;
            $display("FAIL ferr_status: ferr %0d valid %0d done %0d want 1 0 1",
                     n_ferr, n_valid, n_done);
        end
        n_total++;
        if (rx_data !== last_good) begin
            n_bad++;
            $display("FAIL ferr_data: got %h want %h", rx_data, last_good);
        end
    endtask

    task automatic test_glitch();
        bit to;
        clear_mon();
        send_frame(8'h00, 1'b1, 3, 1'b0);
        wait_idle(to);
        last_good = 8'h00;
        n_total++;
        if (n_valid !== 1 || rx_data !== 8'h00) begin
            n_bad++;
            $display("FAIL glitch_vote: valid %0d data %h want 1 00", n_valid, rx_data);
        end
    endtask

    task automatic test_back_to_back();
        bit            to;
        logic [DW-1:0] g0, g1;
        clear_mon();
        send_frame(8'h55, 1'b1, -1, 1'b0);
        send_frame(8'hAA, 1'b1, -1, 1'b0);
        wait_idle(to);
        last_good = 8'hAA;
        g0 = (got_q.size() > 0) ? got_q[0] : 'x;
        g1 = (got_q.size() > 1) ? got_q[1] : 'x;
        n_total++;
        if (n_valid !== 2) begin
            n_bad++;
            $display("FAIL b2b_count: got %0d valid want 2", n_valid);
        end
        n_total++;
        if (g0 !== 8'h55 || g1 !== 8'hAA) begin
            n_bad++;
            $display("FAIL b2b_data: got %h %h want 55 aa", g0, g1);
        end
    endtask

    task automatic test_random();
        bit            to;
        logic [DW-1:0] exp_q[$];
        int            exp_ferr;
        logic [DW-1:0] d, g;
        logic          stop_v;
        clear_mon();
        exp_ferr = 0;
        for (int f = 0; f < 4; f++) begin
            d      = DW'($urandom);
            stop_v = ($urandom_range(0, 3) != 0);
            send_frame(d, stop_v, -1, 1'b0);
            if (stop_v) begin
                exp_q.push_back(d);
                last_good = d;
                tick($urandom_range(0, 40));
            end else begin
                exp_ferr++;
                tick(30);
            end
        end
        wait_idle(to);
        n_total++;
        if (n_valid !== exp_q.size() || n_ferr !== exp_ferr) begin
            n_bad++;
            $display("FAIL rand_count: valid %0d ferr %0d want %0d %0d",
                     n_valid, n_ferr, exp_q.size(), exp_ferr);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (got_q.size() > i) ? got_q[i] : 'x;
            n_total++;
            if (g !== exp_q[i]) begin
                n_bad++;
                $display("FAIL rand_data[%0d]: got %h want %h", i, g, exp_q[i]);
            end
        end
        n_total++;
        if (rx_data !== last_good) begin
            n_bad++;
            $display("FAIL rand_last: got %h want %h", rx_data, last_good);
        end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        bit to;
        clear_mon();
        send_frame(8'h07, 1'b1, -1, 1'b1);
        wait_idle(to);
        n_total++;
        if (n_perr !== 1 || n_valid !== 0 || n_ferr !== 0) begin
            n_bad++;
            $display("FAIL parity_status: perr %0d valid %0d ferr %0d want 1 0 0",
                     n_perr, n_valid, n_ferr);
        end
        n_total++;
        if (rx_data !== last_good) begin
            n_bad++;
            $display("FAIL parity_data: got %h want %h", rx_data, last_good);
        end
    endtask
`endif

    task automatic test_reset_mid();
        clear_mon();
        rx = 1'b0;
        tick(BIT_CLK);
        rx = 1'b1;
        tick(BIT_CLK * 3);
        n_total++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL midrst_busy: got %b want 1 before reset", busy);
        end
        rst = 1'b1;
        tick(1);
        n_total++;
        if ({rx_start, rx_done, busy, rx_valid, frame_err, parity_err} !== 6'b0 ||
            rx_data !== '0) begin
            n_bad++;
            $display("FAIL midrst_outputs: flags %b data %h want 000000 00",
                     {rx_start, rx_done, busy, rx_valid, frame_err, parity_err}, rx_data);
        end
        rst       = 1'b0;
        last_good = '0;
        tick(BIT_CLK * 7);
        n_total++;
        if (n_done !== 0 || n_valid !== 0 || n_start !== 1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst_silent: done %0d valid %0d start %0d busy %b want 0 0 1 0",
                     n_done, n_valid, n_start, busy);
        end
    endtask

    task automatic test_protocol();
        n_total++;
        if (n_viol !== 0) begin
            n_bad++;
            $display("FAIL protocol: got %0d pulse/busy violations want 0", n_viol);
        end
    endtask

    initial begin
        rst = 1'b1;
        rx  = 1'b1;
        test_reset();
        test_good_frame();
        test_false_start();
        test_frame_err();
        test_glitch();
        test_back_to_back();
        test_random();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_reset_mid();
        test_protocol();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
